ysyx_25030093_ifu_prefetch: RTL and testbench
=============================================

YSYX_25030093_IFU_PREFETCH -- requirements
Module: ysyx_25030093_ifu_prefetch

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 4: entries in the fetch buffer; power of two, 2..16.
REQ-003 Parameter INST_W, default 32: instruction/response data width.
REQ-004 The clock SHALL be `clk` and the reset SHALL be `rst`; one clock, reset synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 redirect_valid  in  1  flush the buffer and restart fetch at redirect_pc.
REQ-008 redirect_pc  in  32  new fetch address; bits [1:0] SHALL be ignored (treated as 0).
REQ-009 mem_req_valid  out  1  fetch request valid.
REQ-010 mem_req_ready  in  1  memory accepts the request this cycle.
REQ-011 mem_req_addr  out  32  word-aligned fetch address.
REQ-012 mem_rsp_valid  in  1  response data valid; responses return in request order, any latency >= 1 cycle.
REQ-013 mem_rsp_data  in  INST_W  fetched instruction.
REQ-014 out_valid  out  1  instruction available to the decode stage.
REQ-015 out_ready  in  1  decode stage accepts.
REQ-016 out_inst  out  INST_W  instruction at buffer head.
REQ-017 out_pc  out  32  address of out_inst.

Function
REQ-018 Request handshake: mem_req_valid && mem_req_ready; output handshake: out_valid && out_ready.
REQ-019 Circular buffer of DEPTH entries {pc, inst, filled}; the entry SHALL be allocated at the tail, storing pc = fetch_pc, on each request handshake.
REQ-020 On each request handshake, fetch_pc SHALL advance by 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-021 mem_req_addr SHALL equal fetch_pc.
REQ-022 mem_req_valid SHALL be 1 iff !rst && !redirect_valid && (allocated + drop_cnt) < DEPTH.
REQ-023 mem_req_valid and mem_req_addr SHALL hold stable while mem_req_ready is 0, except when a redirect occurs.
REQ-024 A response with drop_cnt > 0 SHALL be discarded; otherwise it SHALL fill the oldest unfilled entry.
REQ-025 out_valid SHALL be 1 iff the head entry is allocated and filled and redirect_valid is 0; out_inst/out_pc SHALL show that entry.
REQ-026 The head SHALL free on an output handshake.
REQ-027 Allocation, fill and free in the same cycle SHALL all take effect; a full buffer with a simultaneous free SHALL NOT accept a new allocation that cycle (REQ-022 uses the registered count).
REQ-028 Redirect priority: redirect_valid SHALL override every other event in its cycle.
REQ-029 On redirect: all entries SHALL be freed, and fetch_pc SHALL be set to {redirect_pc[31:2],2'b00}.
REQ-030 On redirect: drop_cnt_next = drop_cnt + unfilled_allocated - (mem_rsp_valid ? 1 : 0).
REQ-031 Without redirect: drop_cnt SHALL decrement by one per discarded response.
REQ-032 drop_cnt width SHALL be clog2(DEPTH)+1; (allocated + drop_cnt) SHALL never exceed DEPTH.
REQ-033 The first request after a redirect SHALL be issued no earlier than the cycle following the redirect.
REQ-034 Back-to-back redirects SHALL each take effect; the last one wins.
REQ-035 Throughput: with mem_req_ready=1, 1-cycle response latency and out_ready=1, one instruction per cycle sustained.

Reset
REQ-036 While rst=1: all outputs 0, except mem_req_addr = RESET_PC.
REQ-037 While rst=1: buffer empty, drop_cnt=0, fetch_pc=RESET_PC.
REQ-038 Reset asserted mid-operation SHALL discard all entries and in-flight accounting; responses arriving after reset deasserts SHALL only be produced by post-reset requests (bench guarantees memory is reset together).
REQ-039 First request: mem_req_valid=1 in the first cycle after rst deasserts, addr=RESET_PC.

Verification
REQ-040 Reset release, memory ready, latency 1, out_ready=1 -> out_pc sequence 8000_0000, 8000_0004, 8000_0008..., one per cycle from cycle 2.
REQ-041 out_ready=0, DEPTH=4 -> exactly 4 request handshakes, then mem_req_valid=0; raise out_ready -> in-order drain, fetching resumes.
REQ-042 Latency 3 with 3 requests outstanding; redirect to 8000_0102 -> 3 responses discarded; next out_pc = 8000_0100.
REQ-043 Redirect in the same cycle as a response and an output handshake -> no output counted, drop_cnt = unfilled-1; next out_pc = redirect target.
REQ-044 Two redirects on consecutive cycles (A then B) -> only B's instructions are emitted; no stale data.
REQ-045 fetch_pc at FFFF_FFF8 -> requests FFFF_FFF8, FFFF_FFFC, 0000_0000; rst mid-stream -> outputs cleared, restart at RESET_PC.

Source files
------------

// File: rtl/ysyx_25030093_ifu_prefetch.sv
// Instruction prefetch unit: issues sequential word fetches, buffers in-order
// responses in a circular buffer and hands them to decode, with redirect flush.
module ysyx_25030093_ifu_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 4,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [31:0]       mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [INST_W-1:0] mem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [31:0]       out_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]       r_fetch_pc;
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [AW-1:0]     r_fill_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_unfilled;
  logic [CW-1:0]     r_drop_cnt;
  logic [31:0]       r_pc   [DEPTH];
  logic [INST_W-1:0] r_inst [DEPTH];
  logic [DEPTH-1:0]  r_filled;

  logic [CW:0]       w_inflight;
  logic              w_req_fire;
  logic              w_fill;
  logic              w_drop;
  logic              w_out_fire;
  logic [DEPTH-1:0]  w_alloc_sel;
  logic [DEPTH-1:0]  w_fill_sel;
  logic [DEPTH-1:0]  w_free_sel;

  // Capacity counts both live entries and responses still owed to a flushed stream.
  assign w_inflight    = {1'b0, r_count} + {1'b0, r_drop_cnt};
  assign mem_req_valid = !rst && !redirect_valid && (w_inflight < DEPTH_W);
  assign mem_req_addr  = rst ? RESET_PC : r_fetch_pc;
  assign w_req_fire    = mem_req_valid && mem_req_ready;
  assign w_fill        = mem_rsp_valid && (r_drop_cnt == '0);
  assign w_drop        = mem_rsp_valid && (r_drop_cnt != '0);

  assign out_valid  = !rst && !redirect_valid && (r_count != '0) && r_filled[r_head];
  assign out_inst   = rst ? '0 : r_inst[r_head];
  assign out_pc     = rst ? '0 : r_pc[r_head];
  assign w_out_fire = out_valid && out_ready;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
      assign w_alloc_sel[gi] = w_req_fire && (r_tail == AW'(gi));
      assign w_fill_sel[gi]  = w_fill && (r_fill_ptr == AW'(gi));
      assign w_free_sel[gi]  = w_out_fire && (r_head == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_fill_ptr <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_head     <= '0;
      r_tail     <= '0;
      r_fill_ptr <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
      // A response arriving now retires one of the owed/unfilled slots.
      r_drop_cnt <= r_drop_cnt + r_unfilled - CW'(mem_rsp_valid);
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_tail     <= r_tail + 1'b1;
      end
      if (w_fill) r_fill_ptr <= r_fill_ptr + 1'b1;
      if (w_out_fire) r_head <= r_head + 1'b1;
      r_count    <= r_count + CW'(w_req_fire) - CW'(w_out_fire);
      r_unfilled <= r_unfilled + CW'(w_req_fire) - CW'(w_fill);
      r_drop_cnt <= r_drop_cnt - CW'(w_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) r_filled <= '0;
    else                       r_filled <= (r_filled | w_fill_sel) & ~w_free_sel;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alloc_sel[i]) r_pc[i] <= r_fetch_pc;
      if (w_fill_sel[i])  r_inst[i] <= mem_rsp_data;
    end
  end
endmodule

// File: tb/tb_ysyx_25030093_ifu_prefetch.sv
// Randomised scoreboard bench for the prefetch unit: in-order memory model with
// variable latency, expected instruction stream derived from redirect targets.
module tb_ysyx_25030093_ifu_prefetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int DEPTH  = 4;
  localparam int INST_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = '0;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [31:0]       mem_req_addr;
  logic              mem_rsp_valid = 1'b0;
  logic [INST_W-1:0] mem_rsp_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [INST_W-1:0] out_inst;
  logic [31:0]       out_pc;

  ysyx_25030093_ifu_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .INST_W(INST_W)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  mreq_t       pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] fired_q[$];
  logic [31:0] exp_tail = RESET_PC;
  logic [31:0] exp_req_pc = RESET_PC;
  logic [31:0] prev_addr = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] mon_e;
  int unsigned cyc = 0;
  int unsigned lat_min = 1, lat_max = 1;
  int unsigned ready_pct = 100, oready_pct = 100, redir_pm = 0;
  int checks = 0, passes = 0;
  int req_fires = 0, out_fires = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_1234) + {a[15:0], a[31:16]};
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // One clock of stimulus: memory response from the in-order model plus random handshakes.
  task automatic step(input bit rst_in, input bit force_redir, input logic [31:0] tgt);
    mreq_t m;
    int unsigned pick;
    @(posedge clk);
    #1;
    cyc++;
    rst = rst_in;
    mem_req_ready = ($urandom_range(0, 99) < ready_pct);
    out_ready     = ($urandom_range(0, 99) < oready_pct);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = $urandom;
    redirect_valid = 1'b0;
    if (rst_in) begin
      pend_q.delete();
    end else begin
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        m = pend_q.pop_front();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_word(m.addr);
      end
      if (force_redir) begin
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
      end else if ($urandom_range(0, 999) < redir_pm) begin
        redirect_valid = 1'b1;
        pick = $urandom_range(0, 3);
        case (pick)
          0:       redirect_pc = 32'h8000_0000 + $urandom_range(0, 1023);
          1:       redirect_pc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
          2:       redirect_pc = $urandom;
          default: redirect_pc = $urandom_range(0, 63);
        endcase
      end
    end
  endtask

  // Bounded wait for the next emitted instruction and check its address.
  task automatic expect_next_out(input logic [31:0] pc, input string name);
    fired_q.delete();
    for (int i = 0; i < 40 && fired_q.size() == 0; i++) step(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    check(fired_q.size() > 0, {name, "_timeout"}, 32'(fired_q.size()), 32'd1);
    if (fired_q.size() > 0) check(fired_q[0] == pc, name, fired_q[0], pc);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      check(!mem_req_valid && !out_valid && out_pc == '0 && out_inst == '0, "reset_outputs",
            {30'b0, mem_req_valid, out_valid} | out_pc | out_inst, 32'h0);
      check(mem_req_addr == RESET_PC, "reset_addr", mem_req_addr, RESET_PC);
      exp_q.delete();
      exp_tail   = RESET_PC;
      exp_req_pc = RESET_PC;
      prev_stall = 1'b0;
    end else if (redirect_valid) begin
      check(!mem_req_valid && !out_valid, "redirect_quiet", {30'b0, mem_req_valid, out_valid}, 32'h0);
      exp_q.delete();
      exp_tail   = {redirect_pc[31:2], 2'b00};
      exp_req_pc = exp_tail;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check(mem_req_valid && mem_req_addr == prev_addr, "req_hold", mem_req_addr, prev_addr);
      if (mem_req_valid && mem_req_ready) begin
        check(mem_req_addr == exp_req_pc, "req_addr", mem_req_addr, exp_req_pc);
        exp_req_pc = exp_req_pc + 32'd4;
        pend_q.push_back('{addr: mem_req_addr, due: cyc + $urandom_range(lat_min, lat_max)});
        req_fires++;
      end
      prev_stall = mem_req_valid && !mem_req_ready;
      prev_addr  = mem_req_addr;
      if (out_valid && out_ready) begin
        while (exp_q.size() < 4) begin
          exp_q.push_back(exp_tail);
          exp_tail = exp_tail + 32'd4;
        end
        mon_e = exp_q.pop_front();
        check(out_pc == mon_e, "out_pc", out_pc, mon_e);
        check(out_inst == mem_word(mon_e), "out_inst", out_inst, mem_word(mon_e));
        fired_q.push_back(out_pc);
        out_fires++;
      end
      check(pend_q.size() <= DEPTH, "outstanding", 32'(pend_q.size()), 32'(DEPTH));
    end
  end

  initial begin
    int f0, r0;
    logic [31:0] wrap_pcs [3];
    wrap_pcs[0] = 32'hFFFF_FFF8;
    wrap_pcs[1] = 32'hFFFF_FFFC;
    wrap_pcs[2] = 32'h0000_0000;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);

    // Sustained one-per-cycle streaming out of reset.
    f0 = out_fires;
    r0 = req_fires;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    check(out_fires - f0 == 18, "throughput_out", 32'(out_fires - f0), 32'd18);
    check(req_fires - r0 == 20, "throughput_req", 32'(req_fires - r0), 32'd20);

    // Decode stalled: buffer fills to DEPTH, then drains in order.
    oready_pct = 0;
    r0 = req_fires;
    step(1'b0, 1'b1, 32'h8000_1000);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    check(req_fires - r0 == DEPTH, "full_req_count", 32'(req_fires - r0), 32'(DEPTH));
    check(!mem_req_valid, "full_req_stop", {31'b0, mem_req_valid}, 32'h0);
    oready_pct = 100;
    f0 = out_fires;
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    check(out_fires - f0 >= 8, "drain_resume", 32'(out_fires - f0), 32'd8);

    // Latency 3 with requests outstanding, unaligned redirect target.
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h8000_0102);
    expect_next_out(32'h8000_0100, "redirect_lat3");

    // Redirect coinciding with a response and an output handshake.
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h8000_2000);
    expect_next_out(32'h8000_2000, "redirect_busy");

    // Back-to-back redirects: the second one wins.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h9000_0000);
    step(1'b0, 1'b1, 32'hA000_0000);
    expect_next_out(32'hA000_0000, "redirect_b2b");

    // Address wrap, then reset mid-stream.
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    fired_q.delete();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    check(fired_q.size() >= 3, "wrap_count", 32'(fired_q.size()), 32'd3);
    if (fired_q.size() >= 3)
      for (int i = 0; i < 3; i++) check(fired_q[i] == wrap_pcs[i], "wrap_pc", fired_q[i], wrap_pcs[i]);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    expect_next_out(RESET_PC, "reset_restart");

    // Randomised traffic.
    lat_min = 1;
    lat_max = 4;
    ready_pct = 70;
    oready_pct = 60;
    redir_pm = 30;
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 999) < 2, 1'b0, '0);

    // Liveness once traffic calms down.
    lat_max = 1;
    ready_pct = 100;
    oready_pct = 100;
    redir_pm = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
    f0 = out_fires;
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    check(out_fires - f0 >= 30, "liveness", 32'(out_fires - f0), 32'd30);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
